// File: rtl/line_burst_pkg.sv
// ---------------------------------------------------------------------------
// line_burst_pkg
// Shared types and constants for the cache-line to 4-beat burst adapter.
//   adapter_state_t : transaction sequencing states
//   LINE_W/BEAT_W   : line and memory-beat widths (BEATS*BEAT_W == LINE_W)
//   OFFSET_BITS     : byte-offset bits cleared from the line address
//   line_align()    : clears the byte offset of a line address
// ---------------------------------------------------------------------------
package line_burst_pkg;

    localparam int LINE_W      = 256;
    localparam int BEAT_W      = 64;
    localparam int BEATS       = 4;
    localparam int OFFSET_BITS = 5;
    localparam int ADDR_W      = 32;
    localparam int CNT_W       = $clog2(BEATS);

    // BEATS is a power of two, so the last beat index is the all-ones count.
    localparam logic [CNT_W-1:0] CNT_LAST = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    localparam logic [ADDR_W-1:0] OFFSET_MASK =
        {{(ADDR_W-OFFSET_BITS){1'b0}}, {OFFSET_BITS{1'b1}}};

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_REQ   = 3'd1,
        RD_WAIT  = 3'd2,
        WR_BURST = 3'd3,
        DONE     = 3'd4
    } adapter_state_t;

    function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
        line_align = addr & ~OFFSET_MASK;
    endfunction

endpackage

// File: rtl/line_burst_adapter_chk.sv
// ---------------------------------------------------------------------------
// line_burst_adapter_chk
// Protocol monitor for the arbiter side of line_burst_adapter. Raises a
// sticky flag when line_read and line_write are seen high in the same cycle
// (the adapter resolves this as a write). Cleared only by rst.
//   clk, rst              : clock, synchronous active-high reset
//   line_read, line_write : arbiter request levels
//   both_req_seen         : sticky collision flag
// ---------------------------------------------------------------------------
module line_burst_adapter_chk (
    input  logic clk,
    input  logic rst,
    input  logic line_read,
    input  logic line_write,
    output logic both_req_seen
);

    logic seen_r;
    logic seen_nxt_s;

    // Latch any read/write collision until reset.
    always_comb begin
        seen_nxt_s = seen_r;
        if (line_read && line_write) begin
            seen_nxt_s = 1'b1;
        end else begin
            seen_nxt_s = seen_r;
        end
    end

    // Collision flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            seen_r <= 1'b0;
        end else begin
            seen_r <= seen_nxt_s;
        end
    end

    assign both_req_seen = seen_r;

endmodule

// File: rtl/line_burst_adapter.sv
// ---------------------------------------------------------------------------
// line_burst_adapter
// Turns one 256-bit cache-line request into a 4-beat 64-bit memory burst.
// Reads issue one command then collect four return beats; writes stream four
// beats under bmem_ready. Completion is a one-cycle line_resp pulse.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   line_addr       : line address (offset bits dropped)
//   line_read/write : level requests, held until line_resp (write wins)
//   line_wdata      : write line, beat i = bits [64i+63:64i]
//   line_rdata      : assembled read line, non-zero only with line_resp
//   line_resp       : one-cycle completion pulse
//   bmem_addr       : line-aligned address, held for the transaction
//   bmem_read       : read command, held until bmem_ready
//   bmem_write      : write beat valid
//   bmem_wdata      : current write beat
//   bmem_ready      : memory accepts command / beat
//   bmem_raddr      : line address tagging a returning read beat
//   bmem_rdata      : returning read beat
//   bmem_rvalid     : read beat valid
//   addr_err        : sticky return-address mismatch flag
//
// Build option
//   LINE_BURST_ADAPTER_RADDR_CHECK_EN : when defined, read beats whose
//   bmem_raddr differs from the latched line address are dropped and set
//   addr_err. When undefined, bmem_raddr is ignored and addr_err is 0.
// ---------------------------------------------------------------------------
module line_burst_adapter
    import line_burst_pkg::*;
(
    input  logic [0:0]        clk,
    input  logic [0:0]        rst,
    input  logic [ADDR_W-1:0] line_addr,
    input  logic [0:0]        line_read,
    input  logic [0:0]        line_write,
    input  logic [LINE_W-1:0] line_wdata,
    output logic [LINE_W-1:0] line_rdata,
    output logic [0:0]        line_resp,
    output logic [ADDR_W-1:0] bmem_addr,
    output logic [0:0]        bmem_read,
    output logic [0:0]        bmem_write,
    output logic [BEAT_W-1:0] bmem_wdata,
    input  logic [0:0]        bmem_ready,
    input  logic [ADDR_W-1:0] bmem_raddr,
    input  logic [BEAT_W-1:0] bmem_rdata,
    input  logic [0:0]        bmem_rvalid,
    output logic [0:0]        addr_err
);

`ifdef LINE_BURST_ADAPTER_RADDR_CHECK_EN
    localparam logic RADDR_CHECK_EN = 1'b1;
`else
    localparam logic RADDR_CHECK_EN = 1'b0;
`endif

    adapter_state_t    state_r,       state_nxt_s;
    logic [CNT_W-1:0]  beat_cnt_r,    beat_cnt_nxt_s;
    logic [ADDR_W-1:0] addr_r,        addr_nxt_s;
    logic [LINE_W-1:0] wdata_buf_r,   wdata_buf_nxt_s;
    logic [LINE_W-1:0] beat_buf_r,    beat_buf_nxt_s;
    logic              is_write_r,    is_write_nxt_s;
    logic              addr_err_r,    addr_err_nxt_s;
    logic              line_resp_r,   line_resp_nxt_s;
    logic              bmem_read_r,   bmem_read_nxt_s;
    logic              bmem_write_r,  bmem_write_nxt_s;
    logic [BEAT_W-1:0] bmem_wdata_r,  bmem_wdata_nxt_s;
    logic              addr_match_s;

    // With the check disabled every beat counts as matching.
    assign addr_match_s = RADDR_CHECK_EN ? (bmem_raddr == addr_r) : 1'b1;

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_nxt_s     = state_r;
        beat_cnt_nxt_s  = beat_cnt_r;
        addr_nxt_s      = addr_r;
        wdata_buf_nxt_s = wdata_buf_r;
        beat_buf_nxt_s  = beat_buf_r;
        is_write_nxt_s  = is_write_r;
        addr_err_nxt_s  = addr_err_r;

        case (state_r)
            IDLE: begin
                if (line_write) begin
                    state_nxt_s     = WR_BURST;
                    is_write_nxt_s  = 1'b1;
                    addr_nxt_s      = line_align(line_addr);
                    wdata_buf_nxt_s = line_wdata;
                    beat_cnt_nxt_s  = CNT_ZERO;
                end else if (line_read) begin
                    state_nxt_s    = RD_REQ;
                    is_write_nxt_s = 1'b0;
                    addr_nxt_s     = line_align(line_addr);
                    beat_cnt_nxt_s = CNT_ZERO;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RD_REQ: begin
                if (bmem_ready) begin
                    state_nxt_s    = RD_WAIT;
                    beat_cnt_nxt_s = CNT_ZERO;
                end else begin
                    state_nxt_s = RD_REQ;
                end
            end
            RD_WAIT: begin
                if (bmem_rvalid && addr_match_s) begin
                    beat_buf_nxt_s[beat_cnt_r*BEAT_W +: BEAT_W] = bmem_rdata;
                    beat_cnt_nxt_s = beat_cnt_r + CNT_ONE;
                    if (beat_cnt_r == CNT_LAST) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = RD_WAIT;
                    end
                end else if (bmem_rvalid) begin
                    // Only reachable with the address check enabled.
                    addr_err_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = RD_WAIT;
                end
            end
            WR_BURST: begin
                if (bmem_ready) begin
                    beat_cnt_nxt_s = beat_cnt_r + CNT_ONE;
                    if (beat_cnt_r == CNT_LAST) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = WR_BURST;
                    end
                end else begin
                    state_nxt_s = WR_BURST;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they leave a flop.
        line_resp_nxt_s  = (state_nxt_s == DONE);
        bmem_read_nxt_s  = (state_nxt_s == RD_REQ);
        bmem_write_nxt_s = (state_nxt_s == WR_BURST);
        bmem_wdata_nxt_s = (state_nxt_s == WR_BURST)
                         ? wdata_buf_nxt_s[beat_cnt_nxt_s*BEAT_W +: BEAT_W]
                         : {BEAT_W{1'b0}};
    end

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            beat_cnt_r   <= CNT_ZERO;
            addr_r       <= {ADDR_W{1'b0}};
            wdata_buf_r  <= {LINE_W{1'b0}};
            beat_buf_r   <= {LINE_W{1'b0}};
            is_write_r   <= 1'b0;
            addr_err_r   <= 1'b0;
            line_resp_r  <= 1'b0;
            bmem_read_r  <= 1'b0;
            bmem_write_r <= 1'b0;
            bmem_wdata_r <= {BEAT_W{1'b0}};
        end else begin
            state_r      <= state_nxt_s;
            beat_cnt_r   <= beat_cnt_nxt_s;
            addr_r       <= addr_nxt_s;
            wdata_buf_r  <= wdata_buf_nxt_s;
            beat_buf_r   <= beat_buf_nxt_s;
            is_write_r   <= is_write_nxt_s;
            addr_err_r   <= addr_err_nxt_s;
            line_resp_r  <= line_resp_nxt_s;
            bmem_read_r  <= bmem_read_nxt_s;
            bmem_write_r <= bmem_write_nxt_s;
            bmem_wdata_r <= bmem_wdata_nxt_s;
        end
    end

    assign line_resp  = line_resp_r;
    assign line_rdata = (line_resp_r && !is_write_r) ? beat_buf_r : {LINE_W{1'b0}};
    assign bmem_addr  = addr_r;
    assign bmem_read  = bmem_read_r;
    assign bmem_write = bmem_write_r;
    assign bmem_wdata = bmem_wdata_r;
    assign addr_err   = RADDR_CHECK_EN ? addr_err_r : 1'b0;

endmodule
